// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode command engine: SPI register map,
// FSM state encoding, fill byte and the fixed CRC bytes used without CRC7 logic.
package sd_pkg;

  localparam logic [15:0] SPI_DATA_OFS   = 16'h0000;
  localparam logic [15:0] SPI_STATUS_OFS = 16'h0004;
  localparam logic [15:0] SPI_CS_OFS     = 16'h0008;
  localparam logic [15:0] SPI_DIV_OFS    = 16'h0010;

  localparam logic [7:0] FILL_BYTE = 8'hFF;
  localparam logic [7:0] CRC_CMD0  = 8'h95;
  localparam logic [7:0] CRC_CMD8  = 8'h87;
  localparam logic [7:0] CRC_OTHER = 8'h01;

  // ST_X_* form the shared byte-transfer sub-sequence; ret_q holds the caller.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CS_LO  = 4'd1,
    ST_PRE    = 4'd2,
    ST_SEND   = 4'd3,
    ST_RESP   = 4'd4,
    ST_CS_HI  = 4'd5,
    ST_POST   = 4'd6,
    ST_DONE   = 4'd7,
    ST_X_WR   = 4'd8,
    ST_X_STAT = 4'd9,
    ST_X_RD   = 4'd10
  } state_e;

endpackage

// File: rtl/sd_crc7.sv
// Byte-serial CRC7 (x^7 + x^3 + 1, init 0) accumulator, MSB first.
// Only instantiated when SD_CMD_CRC7_EN is defined.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       upd_i,
  input  logic [7:0] data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    if (clr_i) begin
      crc_d = '0;
    end else if (upd_i) begin
      for (int i = 7; i >= 0; i--) begin
        fb    = crc_d[6] ^ data_i[i];
        crc_d = {crc_d[5:0], 1'b0};
        if (fb) crc_d = crc_d ^ 7'h09;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// Wishbone master issuing one SD SPI-mode command frame through the byte-wide
// SPI peripheral and collecting R1. Define SD_CMD_CRC7_EN for a computed CRC7.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter logic [15:0] SPI_BASE = 16'h0000,
  parameter int          NCR_MAX  = 8,
  parameter int          POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        resp_timeout,
  output logic        bus_timeout,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [3:0]  dbg_state_o
);

  localparam logic [7:0]  NCR_LAST  = 8'(NCR_MAX - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

  // Handshakes: cmd_start is a request taken only in IDLE (busy low, done not
  // pulsing); stb/cyc act as valid and stay high until wb_ack_i, then drop for
  // at least one idle cycle before the next request.
  state_e      state_q, state_d, ret_q, ret_d;
  logic        stb_q, stb_d, we_q, we_d;
  logic [15:0] adr_q, adr_d, dat_q, dat_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d, resp_q, resp_d, cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [15:0] poll_q, poll_d;
  logic        rto_q, rto_d, bto_q, bto_d;

  logic        op_req, op_we, bus_done;
  logic [15:0] op_adr, op_dat;
  logic [2:0]  frame_sel;
  logic [7:0]  frame_nxt, crc_byte;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^wb_dat_i[15:8];

`ifdef SD_CMD_CRC7_EN
  logic [6:0] crc7;
  logic       crc_clr, crc_upd;

  assign crc_clr = (state_q == ST_IDLE) && cmd_start;
  assign crc_upd = (state_q == ST_PRE) || ((state_q == ST_SEND) && (cnt_q < 8'd4));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .reset (reset),
    .clr_i (crc_clr),
    .upd_i (crc_upd),
    .data_i(frame_nxt),
    .crc_o (crc7)
  );

  assign crc_byte = {crc7, 1'b1};
`else
  always_comb begin
    case (idx_q)
      6'd0:    crc_byte = CRC_CMD0;
      6'd8:    crc_byte = CRC_CMD8;
      default: crc_byte = CRC_OTHER;
    endcase
  end
`endif

  // Frame byte about to be loaded: byte 0 from PRE, byte cnt+1 from SEND.
  always_comb begin
    frame_sel = (state_q == ST_PRE) ? 3'd0 : 3'(cnt_q + 8'd1);
    case (frame_sel)
      3'd0:    frame_nxt = {2'b01, idx_q};
      3'd1:    frame_nxt = arg_q[31:24];
      3'd2:    frame_nxt = arg_q[23:16];
      3'd3:    frame_nxt = arg_q[15:8];
      3'd4:    frame_nxt = arg_q[7:0];
      default: frame_nxt = crc_byte;
    endcase
  end

  always_comb begin
    op_req = 1'b0;
    op_we  = 1'b0;
    op_adr = SPI_BASE + SPI_DATA_OFS;
    op_dat = '0;
    case (state_q)
      ST_CS_LO:  begin op_req = 1'b1; op_we = 1'b1; op_adr = SPI_BASE + SPI_CS_OFS; op_dat = 16'h0000; end
      ST_CS_HI:  begin op_req = 1'b1; op_we = 1'b1; op_adr = SPI_BASE + SPI_CS_OFS; op_dat = 16'h0001; end
      ST_X_WR:   begin op_req = 1'b1; op_we = 1'b1; op_dat = {8'h00, tx_q}; end
      ST_X_STAT: begin op_req = 1'b1; op_adr = SPI_BASE + SPI_STATUS_OFS; end
      ST_X_RD:   op_req = 1'b1;
      default:   op_req = 1'b0;
    endcase
  end

  assign bus_done = op_req && stb_q && wb_ack_i;

  always_comb begin
    state_d = state_q; ret_d = ret_q;
    stb_d = stb_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q;
    tx_d = tx_q; rx_d = rx_q; idx_d = idx_q; arg_d = arg_q;
    cnt_d = cnt_q; poll_d = poll_q;
    resp_d = resp_q; rto_d = rto_q; bto_d = bto_q;

    // A state with a bus op launches it in its first cycle with stb low.
    if (op_req && !stb_q) begin
      stb_d = 1'b1;
      we_d  = op_we;
      adr_d = op_adr;
      dat_d = op_dat;
    end
    if (bus_done) stb_d = 1'b0;

    case (state_q)
      ST_IDLE: if (cmd_start) begin
        idx_d   = cmd_index;
        arg_d   = cmd_arg;
        resp_d  = FILL_BYTE;
        rto_d   = 1'b0;
        bto_d   = 1'b0;
        state_d = ST_CS_LO;
      end
      ST_CS_LO: if (bus_done) begin
        tx_d = FILL_BYTE; ret_d = ST_PRE; state_d = ST_X_WR;
      end
      ST_PRE: begin
        tx_d = frame_nxt; cnt_d = '0; ret_d = ST_SEND; state_d = ST_X_WR;
      end
      ST_SEND: begin
        if (cnt_q == 8'd5) begin
          tx_d = FILL_BYTE; cnt_d = '0; ret_d = ST_RESP;
        end else begin
          tx_d = frame_nxt; cnt_d = cnt_q + 8'd1; ret_d = ST_SEND;
        end
        state_d = ST_X_WR;
      end
      ST_RESP: begin
        if (!rx_q[7]) begin
          resp_d = rx_q; state_d = ST_CS_HI;
        end else if (cnt_q == NCR_LAST) begin
          rto_d = 1'b1; resp_d = FILL_BYTE; state_d = ST_CS_HI;
        end else begin
          cnt_d = cnt_q + 8'd1; tx_d = FILL_BYTE; ret_d = ST_RESP; state_d = ST_X_WR;
        end
      end
      ST_CS_HI: if (bus_done) begin
        tx_d = FILL_BYTE; ret_d = ST_POST; state_d = ST_X_WR;
      end
      ST_POST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_X_WR: if (bus_done) begin
        poll_d = '0; state_d = ST_X_STAT;
      end
      ST_X_STAT: if (bus_done) begin
        if (!wb_dat_i[0]) begin
          state_d = ST_X_RD;
        end else if (poll_q == POLL_LAST) begin
          // Stuck peripheral: still release CS, but never retry POST itself.
          bto_d   = 1'b1;
          state_d = (ret_q == ST_POST) ? ST_DONE : ST_CS_HI;
        end else begin
          poll_d = poll_q + 16'd1;
        end
      end
      ST_X_RD: if (bus_done) begin
        rx_d = wb_dat_i[7:0]; state_d = ret_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE; ret_q <= ST_IDLE;
      stb_q <= 1'b0; we_q <= 1'b0; adr_q <= '0; dat_q <= '0;
      tx_q <= FILL_BYTE; rx_q <= FILL_BYTE; idx_q <= '0; arg_q <= '0;
      cnt_q <= '0; poll_q <= '0;
      resp_q <= FILL_BYTE; rto_q <= 1'b0; bto_q <= 1'b0;
    end else begin
      state_q <= state_d; ret_q <= ret_d;
      stb_q <= stb_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
      tx_q <= tx_d; rx_q <= rx_d; idx_q <= idx_d; arg_q <= arg_d;
      cnt_q <= cnt_d; poll_q <= poll_d;
      resp_q <= resp_d; rto_q <= rto_d; bto_q <= bto_d;
    end
  end

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign resp         = resp_q;
  assign resp_timeout = rto_q;
  assign bus_timeout  = bto_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_we_o      = we_q;
  assign wb_stb_o     = stb_q;
  assign wb_cyc_o     = stb_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: SPI peripheral model on Wishbone, table of command
// vectors, plus busy-start and mid-command reset sequences.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        busy, done, resp_timeout, bus_timeout;
  logic [7:0]  resp;
  logic [15:0] wb_adr_o, wb_dat_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic [3:0]  dbg_state;

  sd_cmd_engine dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .busy(busy), .done(done), .resp(resp),
    .resp_timeout(resp_timeout), .bus_timeout(bus_timeout),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cur_vec = -1;
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, act, exp);
    end
  endtask

  // ---------------- SPI peripheral model ----------------
  int   rsp_kind = 0;
  int   stall_xfer = -1;
  bit   rand_dly = 1'b0;
  int   xfer_n = 0;
  int   stat_rd = 0;
  int   stall_reads = 0;
  bit   stall_now = 1'b0;
  logic [7:0] rx_cur = 8'hFF;
  int   dly_cnt = 0;
  int   dly_tgt = 0;
  int   proto_viol = 0;
  logic ack_seen = 1'b0;

  function automatic logic [7:0] rx_for(input int n, input int kind);
    if (n < 7) return 8'hFF;
    case (kind)
      0:       return (n == 9) ? 8'h01 : 8'hFF;
      2:       return (n == 7) ? 8'h00 : 8'hFF;
      default: return 8'hFF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      wb_ack_i <= 1'b0;
      dly_cnt  <= 0;
      dly_tgt  <= 0;
    end else begin
      wb_ack_i <= 1'b0;
      if (wb_stb_o && wb_cyc_o && !wb_ack_i) begin
        if (dly_cnt < dly_tgt) begin
          dly_cnt <= dly_cnt + 1;
        end else begin
          wb_ack_i <= 1'b1;
          dly_cnt  <= 0;
          dly_tgt  <= rand_dly ? int'($urandom_range(0, 5)) : 0;
          if (wb_we_o) begin
            case (wb_adr_o)
              SPI_DATA_OFS: begin
                log_q.push_back({8'hD0, wb_dat_o[7:0]});
                rx_cur    <= rx_for(xfer_n, rsp_kind);
                stall_now <= (xfer_n == stall_xfer);
                xfer_n    <= xfer_n + 1;
                stat_rd   <= 0;
              end
              SPI_CS_OFS: begin
                log_q.push_back({8'hC0, wb_dat_o[7:0]});
                if (wb_dat_o[0] == 1'b0) xfer_n <= 0;
              end
              SPI_DIV_OFS: log_q.push_back({8'hD1, wb_dat_o[7:0]});
              default:     log_q.push_back({8'hEE, wb_adr_o[7:0]});
            endcase
          end else begin
            case (wb_adr_o)
              SPI_STATUS_OFS: begin
                wb_dat_i <= {15'h0, (stall_now || stat_rd == 0)};
                stat_rd  <= stat_rd + 1;
                if (stall_now) stall_reads <= stat_rd + 1;
              end
              SPI_DATA_OFS: wb_dat_i <= {8'h00, rx_cur};
              default:      wb_dat_i <= 16'hDEAD;
            endcase
          end
        end
      end
    end
  end

  // stb/cyc must match, and stb must not be high in the cycle after an ack.
  always @(negedge clk) begin
    if (reset) begin
      if (ack_seen && wb_stb_o) proto_viol++;
      if (wb_stb_o !== wb_cyc_o) proto_viol++;
    end
    ack_seen <= wb_ack_i;
  end

  // ---------------- expected-value helpers ----------------
  function automatic logic [7:0] crc_ref(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CMD_CRC7_EN
    logic [46:0] m;
    m = {2'b01, idx, arg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return {m[6:0], 1'b1};
`else
    if (arg == 32'hFFFF_FFFF) return 8'h01;
    return (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
`endif
  endfunction

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          kind;
    int          stall;
    bit          rdly;
    bit          poke;
    logic [7:0]  exp_resp;
    logic        exp_rto;
    logic        exp_bto;
    logic [7:0]  exp_crc;
  } vec_t;

  vec_t vecs[5];

  task automatic build_exp(input vec_t v);
    logic [7:0] fr[6];
    int nf, nr;
    fr[0] = {2'b01, v.idx};
    fr[1] = v.arg[31:24];
    fr[2] = v.arg[23:16];
    fr[3] = v.arg[15:8];
    fr[4] = v.arg[7:0];
    fr[5] = v.exp_crc;
    exp_q.delete();
    exp_q.push_back(16'hC000);
    exp_q.push_back(16'hD0FF);
    nf = (v.stall > 0) ? v.stall : 6;
    for (int i = 0; i < nf; i++) exp_q.push_back({8'hD0, fr[i]});
    if (v.stall <= 0) begin
      nr = (v.kind == 0) ? 3 : (v.kind == 1) ? 8 : 1;
      for (int i = 0; i < nr; i++) exp_q.push_back(16'hD0FF);
    end
    exp_q.push_back(16'hC001);
    exp_q.push_back(16'hD0FF);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit poke,
                         output bit got_done, output logic [7:0] r,
                         output logic rto, output logic bto);
    @(negedge clk);
    cmd_index = idx;
    cmd_arg   = arg;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_index = 6'h3F;
    cmd_arg   = 32'hFFFF_FFFF;
    check("busy_after_start", busy, 1);
    got_done = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      cmd_start = (poke && c == 20);
      @(negedge clk);
    end
    cmd_start = 1'b0;
    r   = resp;
    rto = resp_timeout;
    bto = bus_timeout;
    check("done_seen", got_done, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic do_vec(input vec_t v);
    bit got;
    logic [7:0] r;
    logic rto, bto;
    rsp_kind    = v.kind;
    stall_xfer  = v.stall;
    rand_dly    = v.rdly;
    stall_reads = 0;
    log_q.delete();
    build_exp(v);
    run_cmd(v.idx, v.arg, v.poke, got, r, rto, bto);
    check("resp", r, v.exp_resp);
    check("resp_timeout", rto, v.exp_rto);
    check("bus_timeout", bto, v.exp_bto);
    check("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("log_entry_%0d", i), (i < log_q.size()) ? log_q[i] : 16'hFFFF, exp_q[i]);
    if (v.stall > 0) check("status_reads", stall_reads, 1023);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", dbg_state, 4'(ST_IDLE));
    if (v.poke) begin
      repeat (3) @(negedge clk);
      check("poke_not_queued", busy, 0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{6'd0,  32'h0000_0000, 0, -1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 8'h95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 2, -1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h87};
    vecs[2] = '{6'd17, 32'h0000_1000, 1, -1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, crc_ref(6'd17, 32'h0000_1000)};
    vecs[3] = '{6'd12, 32'h1234_5678, 0, 4,  1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, crc_ref(6'd12, 32'h1234_5678)};
    vecs[4] = '{6'd55, 32'h0000_0000, 0, -1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, crc_ref(6'd55, 32'h0000_0000)};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp", resp, 8'hFF);
    check("rst_rto", resp_timeout, 0);
    check("rst_bto", bus_timeout, 0);
    check("rst_state", dbg_state, 4'(ST_IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      cur_vec = i;
      do_vec(vecs[i]);
    end

    // Reset while SEND is transferring frame byte 2, then a clean CMD0.
    cur_vec = 10;
    rsp_kind = 0; stall_xfer = -1; rand_dly = 1'b0;
    log_q.delete();
    @(negedge clk);
    cmd_index = 6'd0; cmd_arg = 32'h0; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (log_q.size() >= 5) break;
      @(negedge clk);
    end
    check("reach_send_byte2", (log_q.size() >= 5), 1);
    check("in_send_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_stb", wb_stb_o, 0);
    check("mid_rst_cyc", wb_cyc_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resp", resp, 8'hFF);
    reset = 1'b1;
    @(negedge clk);
    cur_vec = 11;
    do_vec(vecs[0]);

    check("wb_protocol_violations", proto_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
